// File: rtl/within_seq_monitor_if.sv
// -----------------------------------------------------------------------------
// within_seq_monitor_if
//
// Bundles the signals that pass between the stimulus side and the in-circuit
// monitor for the property "after rose(d), ##[A_MIN:$] a completes within
// b ##[MIN_GAP:MAX_GAP] c".
//
// Signals:
//   a, b, c, d   monitored single-bit inputs, synchronous to the monitor clock
//   busy         an evaluation is in progress
//   pass, fail   one-cycle verdict pulses (never both high)
//   fail_reason  0 none, 1 NO_B, 2 NO_A, 3 NO_C; held until the next verdict
//   pass_cnt     saturating count of passes
//   fail_cnt     saturating count of fails
//   drop_cnt     saturating count of triggers ignored while busy
//
// Modports:
//   master  stimulus side: drives a/b/c/d, observes the monitor results
//   slave   monitor side: samples a/b/c/d, drives the results
// -----------------------------------------------------------------------------
interface within_seq_monitor_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_reason;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output a,
    output b,
    output c,
    output d,
    input  busy,
    input  pass,
    input  fail,
    input  fail_reason,
    input  pass_cnt,
    input  fail_cnt,
    input  drop_cnt
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    input  d,
    output busy,
    output pass,
    output fail,
    output fail_reason,
    output pass_cnt,
    output fail_cnt,
    output drop_cnt
  );

endinterface

// File: rtl/within_seq_monitor.sv
// -----------------------------------------------------------------------------
// within_seq_monitor
//
// Synthesizable checker for the temporal property
//   rose(d) |=> (##[A_MIN:$] a) within (b ##[MIN_GAP:MAX_GAP] c)
// for silicon/FPGA use where no assertion engine is available.
//
// Evaluations are non-overlapping. The cycle after the trigger (S) must carry
// b; the closing c must land at offset MIN_GAP..MAX_GAP from S, and a qualifying
// a (offset >= A_MIN) must occur at or before that c.
//
// Parameters:
//   MIN_GAP  minimum b-to-c distance (1..MAX_GAP)
//   MAX_GAP  maximum b-to-c distance (MIN_GAP..15)
//   A_MIN    earliest offset from S at which a counts (0..MAX_GAP)
//   CNT_W    width of each event counter; must match the interface CNT_W
//
// Ports:
//   clk      sole clock, posedge sampling
//   rst      asynchronous active-high reset
//   mon      slave side of within_seq_monitor_if (a/b/c/d in, results out)
// -----------------------------------------------------------------------------
module within_seq_monitor #(
  parameter int unsigned MIN_GAP = 3,
  parameter int unsigned MAX_GAP = 5,
  parameter int unsigned A_MIN   = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  within_seq_monitor_if.slave   mon
);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun
  } state_e;

  typedef enum logic [1:0] {
    ReasonNone = 2'd0,
    ReasonNoB  = 2'd1,
    ReasonNoA  = 2'd2,
    ReasonNoC  = 2'd3
  } reason_e;

  // Offsets live in a 4-bit counter, so compare against 4-bit constants.
  localparam logic [3:0] MinGapK  = 4'(MIN_GAP);
  localparam logic [3:0] MaxGapK  = 4'(MAX_GAP);
  localparam logic [3:0] AMinK    = 4'(A_MIN);
  localparam logic       AMinZero = (A_MIN == 0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             d_q;
  logic [3:0]       k_q, k_d;
  logic             a_seen_q, a_seen_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  reason_e          reason_q, reason_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic rose;
  logic seen;
  logic verdict_pass;
  logic verdict_fail;
  logic drop_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Trigger and qualifying-a detection
  // ---------------------------------------------------------------------------
  assign rose = mon.d & ~d_q;

  // a counts if already seen, or if it arrives now at a late enough offset;
  // same-cycle a with the closing c therefore qualifies.
  assign seen = a_seen_q | (mon.a & (k_q >= AMinK));

  // ---------------------------------------------------------------------------
  // Next-state and verdict logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    a_seen_d     = a_seen_q;
    reason_d     = reason_q;
    verdict_pass = 1'b0;
    verdict_fail = 1'b0;
    drop_evt     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rose) begin
          state_d = StArmed;
        end
      end

      // This edge is S: b must be present here.
      StArmed: begin
        if (!mon.b) begin
          verdict_fail = 1'b1;
          reason_d     = ReasonNoB;
          state_d      = StIdle;
        end else begin
          a_seen_d = mon.a & AMinZero;
          k_d      = 4'd1;
          state_d  = StRun;
        end
      end

      StRun: begin
        if (mon.c && (k_q >= MinGapK) && seen) begin
          verdict_pass = 1'b1;
          reason_d     = ReasonNone;
          state_d      = StIdle;
        end else if (k_q == MaxGapK) begin
          verdict_fail = 1'b1;
          reason_d     = seen ? ReasonNoC : ReasonNoA;
          state_d      = StIdle;
        end else begin
          // An early c, or a c without a qualifying a, just keeps waiting.
          a_seen_d = seen;
          k_d      = k_q + 4'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Tidy the per-evaluation context once a verdict is produced.
    if (verdict_pass || verdict_fail) begin
      k_d      = 4'd0;
      a_seen_d = 1'b0;
    end

    // Triggers while busy: accepted on a verdict edge (back-to-back), dropped
    // otherwise.
    if (state_q != StIdle) begin
      if (verdict_pass || verdict_fail) begin
        if (rose) begin
          state_d = StArmed;
        end
      end else if (rose) begin
        drop_evt = 1'b1;
      end
    end
  end

  always_comb begin
    pass_d     = verdict_pass;
    fail_d     = verdict_fail;
    pass_cnt_d = verdict_pass ? sat_inc(pass_cnt_q) : pass_cnt_q;
    fail_cnt_d = verdict_fail ? sat_inc(fail_cnt_q) : fail_cnt_q;
    drop_cnt_d = drop_evt     ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      d_q        <= 1'b0;
      k_q        <= 4'd0;
      a_seen_q   <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      reason_q   <= ReasonNone;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      d_q        <= mon.d;
      k_q        <= k_d;
      a_seen_q   <= a_seen_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      reason_q   <= reason_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mon.busy        = (state_q != StIdle);
  assign mon.pass        = pass_q;
  assign mon.fail        = fail_q;
  assign mon.fail_reason = reason_q;
  assign mon.pass_cnt    = pass_cnt_q;
  assign mon.fail_cnt    = fail_cnt_q;
  assign mon.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_within_seq_monitor.sv
module tb_within_seq_monitor;

  localparam int MinGap = 3;
  localparam int MaxGap = 5;
  localparam int AMin   = 1;

  logic clk;
  logic rst;
  bit   cmp_en;

  int checks = 0;
  int errors = 0;

  within_seq_monitor_if #(.CNT_W(8)) bus ();
  within_seq_monitor_if #(.CNT_W(2)) bus2 ();

  // The 2-bit-counter instance sees exactly the same stimulus.
  assign bus2.a = bus.a;
  assign bus2.b = bus.b;
  assign bus2.c = bus.c;
  assign bus2.d = bus.d;

  within_seq_monitor #(
    .MIN_GAP(MinGap),
    .MAX_GAP(MaxGap),
    .A_MIN  (AMin),
    .CNT_W  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(bus)
  );

  within_seq_monitor #(
    .MIN_GAP(MinGap),
    .MAX_GAP(MaxGap),
    .A_MIN  (AMin),
    .CNT_W  (2)
  ) dut_sat (
    .clk(clk),
    .rst(rst),
    .mon(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: keeps the history of a and judges each evaluation by
  // scanning it, straight from the property's rules.
  // ---------------------------------------------------------------------------
  bit ha [0:4095];
  int n        = 0;   // global edge index
  bit m_active = 0;   // evaluation in flight
  int m_s      = 0;   // edge index of S
  bit m_dprev  = 0;
  int e_pass   = 0;
  int e_fail   = 0;
  int e_reason = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_drop   = 0;

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_dprev  = 0;
    e_pass   = 0;
    e_fail   = 0;
    e_reason = 0;
    n_pass   = 0;
    n_fail   = 0;
    n_drop   = 0;
  endtask

  task automatic model_step();
    bit rose;
    bit was_active;
    bit seen;
    bit verdict;
    int off;
    ha[n]   = bus.a;
    rose    = bus.d && !m_dprev;
    m_dprev = bus.d;
    e_pass  = 0;
    e_fail  = 0;
    verdict = 0;
    was_active = m_active;
    if (m_active) begin
      off = n - m_s;
      if (off == 0) begin
        if (!bus.b) begin
          e_fail   = 1;
          e_reason = 1;
        end
      end else begin
        seen = 0;
        for (int j = AMin; j <= off; j++) begin
          if (ha[m_s + j]) seen = 1;
        end
        if (bus.c && off >= MinGap && seen) begin
          e_pass   = 1;
          e_reason = 0;
        end else if (off == MaxGap) begin
          e_fail   = 1;
          e_reason = seen ? 3 : 2;
        end
      end
      verdict = (e_pass != 0) || (e_fail != 0);
      if (verdict) begin
        m_active = 0;
        n_pass += e_pass;
        n_fail += e_fail;
      end else if (rose) begin
        n_drop++;
      end
    end
    if (rose && (!was_active || verdict)) begin
      m_active = 1;
      m_s      = n + 1;
    end
    n++;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("busy",         bus.busy,        32'(m_active));
        chk("pass",         bus.pass,        32'(e_pass));
        chk("fail",         bus.fail,        32'(e_fail));
        chk("fail_reason",  bus.fail_reason, 32'(e_reason));
        chk("pass_cnt",     bus.pass_cnt,    32'(sat(n_pass, 8)));
        chk("fail_cnt",     bus.fail_cnt,    32'(sat(n_fail, 8)));
        chk("drop_cnt",     bus.drop_cnt,    32'(sat(n_drop, 8)));
        chk("sat_busy",     bus2.busy,       32'(m_active));
        chk("sat_pass",     bus2.pass,       32'(e_pass));
        chk("sat_fail",     bus2.fail,       32'(e_fail));
        chk("sat_pass_cnt", bus2.pass_cnt,   32'(sat(n_pass, 2)));
        chk("sat_fail_cnt", bus2.fail_cnt,   32'(sat(n_fail, 2)));
        chk("sat_drop_cnt", bus2.drop_cnt,   32'(sat(n_drop, 2)));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // Inputs set after a negedge are sampled by the following posedge.
  task automatic cyc(input logic ia, input logic ib, input logic ic, input logic id);
    @(negedge clk);
    bus.a = ia;
    bus.b = ib;
    bus.c = ic;
    bus.d = id;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    cmp_en = 1'b0;
    bus.a  = 1'b0;
    bus.b  = 1'b0;
    bus.c  = 1'b0;
    bus.d  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     bus.busy,        32'd0);
    chk("rst_pass",     bus.pass,        32'd0);
    chk("rst_fail",     bus.fail,        32'd0);
    chk("rst_reason",   bus.fail_reason, 32'd0);
    chk("rst_pass_cnt", bus.pass_cnt,    32'd0);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // 1: clean pass at S+4
    cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    after_edge();
    chk("s1_pass",       bus.pass,     32'd1);
    chk("s1_pass_cnt",   bus.pass_cnt, 32'd1);
    chk("s1_model_pass", 32'(n_pass),  32'd1);
    cyc(0, 0, 0, 0);
    after_edge();
    chk("s1_busy_after", bus.busy, 32'd0);
    chk("s1_pass_after", bus.pass, 32'd0);

    // 2: missing b
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    after_edge();
    chk("s2_fail",     bus.fail,        32'd1);
    chk("s2_reason",   bus.fail_reason, 32'd1);
    chk("s2_fail_cnt", bus.fail_cnt,    32'd1);
    cyc(0, 0, 0, 0);

    // 3a: a only at S, c at S+3 -> NO_A at S+5
    cyc(0, 0, 0, 1); cyc(1, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 0);
    after_edge();
    chk("s3a_no_verdict", 32'({bus.pass, bus.fail}), 32'd0);
    chk("s3a_busy",       bus.busy,                  32'd1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    after_edge();
    chk("s3a_fail",         bus.fail,        32'd1);
    chk("s3a_reason",       bus.fail_reason, 32'd2);
    chk("s3a_model_reason", 32'(e_reason),   32'd2);
    cyc(0, 0, 0, 0);

    // 3b: a at S+1, c only at S+2 -> NO_C at S+5
    cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    after_edge();
    chk("s3b_fail",   bus.fail,        32'd1);
    chk("s3b_reason", bus.fail_reason, 32'd3);
    cyc(0, 0, 0, 0);

    // 4: c without a at S+3/S+4, a and c together at S+5, stray c at S+6
    cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(1, 0, 1, 0);
    after_edge();
    chk("s4_pass",   bus.pass,        32'd1);
    chk("s4_reason", bus.fail_reason, 32'd0);
    cyc(0, 0, 1, 0);
    after_edge();
    chk("s4_stray_c", 32'({bus.busy, bus.pass, bus.fail}), 32'd0);
    cyc(0, 0, 0, 0);

    // 5a: second rose at S+2 is dropped
    cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    after_edge();
    chk("s5a_drop", bus.drop_cnt, 32'd1);
    cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
    after_edge();
    chk("s5a_pass", bus.pass, 32'd1);
    cyc(0, 0, 0, 0);

    // 5b: rose on the verdict edge starts a new evaluation back-to-back
    cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 1);
    after_edge();
    chk("s5b_pass", bus.pass, 32'd1);
    chk("s5b_busy", bus.busy, 32'd1);
    cyc(0, 1, 0, 0);
    after_edge();
    chk("s5b_busy_s2", bus.busy, 32'd1);
    chk("s5b_no_nob",  bus.fail, 32'd0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 1, 0);
    after_edge();
    chk("s5b_pass2",    bus.pass,      32'd1);
    chk("tot_pass_cnt", bus.pass_cnt,  32'd5);
    chk("tot_fail_cnt", bus.fail_cnt,  32'd3);
    chk("tot_sat_pass", bus2.pass_cnt, 32'd3);
    cyc(0, 0, 0, 0);

    // 6a: asynchronous reset mid-evaluation
    cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    after_edge();
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_busy",     bus.busy,        32'd0);
    chk("s6_rst_pass_cnt", bus.pass_cnt,    32'd0);
    chk("s6_rst_fail_cnt", bus.fail_cnt,    32'd0);
    chk("s6_rst_drop_cnt", bus.drop_cnt,    32'd0);
    chk("s6_rst_reason",   bus.fail_reason, 32'd0);
    @(negedge clk);
    bus.c = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    bus.c = 1'b0;
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    after_edge();
    chk("s6_no_verdict", 32'({bus.pass, bus.fail}), 32'd0);

    // 6b: five passes saturate the 2-bit counter at 3
    for (int p = 0; p < 5; p++) begin
      cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
    end
    after_edge();
    chk("s6_pass_cnt8", bus.pass_cnt,  32'd5);
    chk("s6_pass_cnt2", bus2.pass_cnt, 32'd3);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
